arm_mem_responder: RTL and testbench

Memory-side responder for the ARM core's data port: accepts word-addressed read/write requests with a 4-bit byte-lane write mask and returns read data after a programmable number of wait states. Sits between the core's `mem_addr`/`mem_data_in`/`mem_write_en`/`mem_data_out` signals and a byte-writable SRAM. Replaces the zero-latency behavioural memory so that multi-cycle memory behaviour can be exercised.

---
 rtl/arm_mem_pkg.sv | 20 ++
 rtl/arm_sram_bytewe.sv | 29 ++
 rtl/arm_mem_responder.sv | 93 +++++++++
 tb/tb_arm_mem_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the ARM data-port memory responder.
// Holds the responder FSM encoding, write-mask shorthands and the range helper.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam logic [3:0] MASK_READ = 4'b0000;
  localparam logic [3:0] MASK_WORD = 4'b1111;
  localparam int         WAIT_W    = 4;

  // A word address is implemented only when every bit above the array index is zero.
  function automatic logic addr_in_range(input logic [29:0] addr, input int addr_w);
    return (addr >> addr_w) == 30'd0;
  endfunction

endpackage

// File: rtl/arm_sram_bytewe.sv
// Byte-writable synchronous word array: registered read returns the word as it was
// before any lane write on the same edge. Contents are not reset.
module arm_sram_bytewe
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/arm_mem_responder.sv
// Memory-side responder for the ARM data port: one outstanding request, response after
// WAIT_CYCLES wait states, held until resp_ready; req_ready is high only while idle.
module arm_mem_responder
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [29:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  mem_state_t        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              err_q;
  logic              accept;
  logic              in_range;
  logic [31:0]       sram_rdata;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready && rst_b;
  assign in_range  = addr_in_range(req_addr, ADDR_W);

  // The array's read register doubles as the response data register: it only
  // updates on an in-range accept, so it is stable for the whole RESP phase.
  arm_sram_bytewe #(
    .ADDR_W (ADDR_W)
  ) u_sram (
    .clk   (clk),
    .en    (accept && in_range),
    .addr  (req_addr[ADDR_W-1:0]),
    .we    (req_wmask),
    .wdata (req_wdata),
    .rdata (sram_rdata)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      resp_valid <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            err_q <= !in_range;
            if (WAIT_CYCLES == 0) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !err_q) ? sram_rdata : 32'h0;

endmodule

// File: tb/tb_arm_mem_responder.sv
// Directed plus randomized bench for arm_mem_responder against a word-array model;
// a second instance runs with zero wait states for the throughput case.
module tb_arm_mem_responder;
  import arm_mem_pkg::*;

  localparam int ADDR_W = 14;
  localparam int WAITS  = 2;
  localparam logic [29:0] POISON_ADDR = 30'h0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_b;

  logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
  logic [29:0] req_addr;
  logic [31:0] req_wdata, resp_rdata;
  logic [3:0]  req_wmask;

  logic        req_valid_z, req_ready_z, resp_valid_z, resp_ready_z, resp_err_z;
  logic [29:0] req_addr_z;
  logic [31:0] req_wdata_z, resp_rdata_z;
  logic [3:0]  req_wmask_z;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [int];
  logic [31:0] wd_z [4];

  arm_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAITS)) dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  arm_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_addr(req_addr_z),
    .req_wdata(req_wdata_z), .req_wmask(req_wmask_z),
    .resp_valid(resp_valid_z), .resp_ready(resp_ready_z),
    .resp_rdata(resp_rdata_z), .resp_err(resp_err_z)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] m);
    logic [31:0] bm;
    bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (old & ~bm) | (wd & bm);
  endfunction

  // One complete transaction on the WAIT_CYCLES=2 instance, holding the response
  // for 'hold' cycles with a rejected request presented meanwhile.
  task automatic txn(input string tag, input logic [29:0] a, input logic [31:0] wd,
                     input logic [3:0] m, input int hold);
    logic        exp_err, known;
    logic [31:0] exp_d, first_d;
    int          lat;
    exp_err = (a >> ADDR_W) != 30'd0;
    known   = exp_err || model.exists(int'(a));
    exp_d   = (exp_err || !known) ? 32'h0 : model[int'(a)];
    if (!exp_err && m != MASK_READ && (known || m == MASK_WORD))
      model[int'(a)] = merge(exp_d, wd, m);

    chk({tag, " req_ready before"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = a; req_wdata = wd; req_wmask = m;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 30'($urandom);
    req_wdata = $urandom;
    req_wmask = 4'($urandom);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(WAITS + 1));
    if (resp_valid) begin
      first_d = resp_rdata;
      chk({tag, " err"}, 32'(resp_err), 32'(exp_err));
      if (known) chk({tag, " rdata"}, resp_rdata, exp_d);
      for (int h = 0; h < hold; h++) begin
        if (h == 0) begin
          req_valid = 1'b1; req_addr = POISON_ADDR; req_wdata = 32'hBAD0BAD0; req_wmask = MASK_WORD;
        end
        @(negedge clk);
        chk({tag, " hold valid"}, 32'(resp_valid), 32'd1);
        chk({tag, " hold rdata"}, resp_rdata, first_d);
        chk({tag, " hold err"}, 32'(resp_err), 32'(exp_err));
        chk({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk({tag, " idle req_ready"}, 32'(req_ready), 32'd1);
      chk({tag, " idle valid"}, 32'(resp_valid), 32'd0);
      chk({tag, " idle rdata"}, resp_rdata, 32'h0);
      chk({tag, " idle err"}, 32'(resp_err), 32'd0);
    end
  endtask

  initial begin
    int          k;
    logic [29:0] a;
    logic [31:0] wd;

    rst_b = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0; resp_ready = 1'b0;
    req_valid_z = 1'b0; req_addr_z = '0; req_wdata_z = '0; req_wmask_z = '0; resp_ready_z = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'h0);
    chk("reset resp_err", 32'(resp_err), 32'd0);
    rst_b = 1'b1;
    @(negedge clk);

    txn("init0", 30'h0, 32'hCAFEF00D, MASK_WORD, 0);
    txn("wr10", 30'h10, 32'hDEADBEEF, MASK_WORD, 0);
    txn("rd10", 30'h10, 32'h0, MASK_READ, 0);
    txn("part10", 30'h10, 32'h0000AA00, 4'b0010, 0);
    txn("rd10b", 30'h10, 32'h0, MASK_READ, 0);
    txn("oor", 30'h4000, 32'h11111111, MASK_WORD, 0);
    txn("rd0", 30'h0, 32'h0, MASK_READ, 0);
    txn("bp", 30'h10, 32'h0, MASK_READ, 5);
    txn("rd0 after bp", 30'h0, 32'h0, MASK_READ, 0);

    // Reset one cycle after accepting a write; a request stays presented during reset.
    req_valid = 1'b1; req_addr = 30'h20; req_wdata = 32'h12345678; req_wmask = MASK_WORD;
    @(negedge clk);
    rst_b = 1'b0;
    req_wdata = 32'hFFFFFFFF;
    #1;
    chk("rst mid resp_valid", 32'(resp_valid), 32'd0);
    chk("rst mid req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    req_valid = 1'b0;
    model[32'h20] = 32'h12345678;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("post rst no resp", 32'(resp_valid), 32'd0);
    end
    txn("rd20", 30'h20, 32'h0, MASK_READ, 0);

    for (int i = 0; i < 8; i++)
      txn("rnd init", 30'h100 + 30'(i), $urandom, MASK_WORD, 0);
    for (int i = 0; i < 60; i++) begin
      a = 30'h100 + 30'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) a = a | (30'($urandom_range(1, 16'hFFFF)) << ADDR_W);
      txn("rnd", a, $urandom, 4'($urandom), int'($urandom_range(0, 3)));
    end
    txn("rd0 final", 30'h0, 32'h0, MASK_READ, 0);

    // Zero-wait instance: four writes then four reads, resp_ready tied high.
    k = 0;
    resp_ready_z = 1'b1;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      chk("z req_ready", 32'(req_ready_z), 32'(c % 2 == 0));
      chk("z resp_valid", 32'(resp_valid_z), 32'(c % 2 == 1));
      if (resp_valid_z) begin
        chk("z err", 32'(resp_err_z), 32'd0);
        if (k - 1 >= 4) chk("z rdata", resp_rdata_z, wd_z[k-5]);
      end
      if (req_ready_z) begin
        if (k < 8) begin
          wd = $urandom;
          req_valid_z = 1'b1;
          req_addr_z  = 30'(k % 4);
          req_wmask_z = (k < 4) ? MASK_WORD : MASK_READ;
          req_wdata_z = wd;
          if (k < 4) wd_z[k] = wd;
          k++;
        end else begin
          req_valid_z = 1'b0;
        end
      end
    end
    chk("z accepts", 32'(k), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
